// File: rtl/snn_axil_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snn_axil_ctrl_if                                             |
// | Description : AXI4-Lite bus bundle between the host and snn_axil_ctrl.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface snn_axil_ctrl_if #(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                  AWPROT;
  logic                        AWVALID;
  logic                        AWREADY;
  logic [AXI_DATA_WIDTH-1:0]   WDATA;
  logic [AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                        WVALID;
  logic                        WREADY;
  logic [1:0]                  BRESP;
  logic                        BVALID;
  logic                        BREADY;
  logic [AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                  ARPROT;
  logic                        ARVALID;
  logic                        ARREADY;
  logic [AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                  RRESP;
  logic                        RVALID;
  logic                        RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface
`default_nettype wire

// File: rtl/snn_axil_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snn_axil_ctrl                                                |
// | Description : AXI4-Lite slave holding the SNN image buffer, control and    |
// |               status registers and the start/done handshake with the core. |
// |               Define SNN_AXIL_IRQ_EN to enable the completion interrupt.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module snn_axil_ctrl #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int IMAGE_SIZE     = 256,
  parameter int PIXEL_BITS     = 8,
  parameter int M              = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  snn_axil_ctrl_if.slave        axil,
  output logic [PIXEL_BITS-1:0] IMAGE [IMAGE_SIZE],
  output logic                  NEW_IMAGE,
  input  logic                  SNN_DONE,
  input  logic [M-1:0]          INFERED_DIGIT,
  output logic                  IRQ
);

  localparam int PPW    = AXI_DATA_WIDTH / PIXEL_BITS;
  localparam int NWORDS = (IMAGE_SIZE + PPW - 1) / PPW;
  localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int WAW    = AXI_ADDR_WIDTH - 2;
  localparam int NLANES = AXI_DATA_WIDTH / 8;
  localparam logic [WAW-1:0] IMG_BASE = WAW'(32'h100);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic [M-1:0] result_q, result_d;
  logic [31:0] count_q, count_d;
  logic        new_image_q, new_image_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic        irq_en_q;
  logic        irq_q;

  // ---------------- address decode ----------------
  logic [WAW-1:0] w_wr_word, w_rd_word, w_wr_off, w_rd_off;
  logic           w_wr_reg, w_rd_reg, w_wr_img, w_rd_img;
  logic [KW-1:0]  w_wr_k, w_rd_k;

  assign w_wr_word = axil.AWADDR[AXI_ADDR_WIDTH-1:2];
  assign w_rd_word = axil.ARADDR[AXI_ADDR_WIDTH-1:2];
  assign w_wr_off  = w_wr_word - IMG_BASE;
  assign w_rd_off  = w_rd_word - IMG_BASE;
  assign w_wr_reg  = (w_wr_word < WAW'(4));
  assign w_rd_reg  = (w_rd_word < WAW'(4));
  assign w_wr_img  = (w_wr_word >= IMG_BASE) && (w_wr_off < WAW'(NWORDS));
  assign w_rd_img  = (w_rd_word >= IMG_BASE) && (w_rd_off < WAW'(NWORDS));
  assign w_wr_k    = w_wr_off[KW-1:0];
  assign w_rd_k    = w_rd_off[KW-1:0];

  // ---------------- handshakes ----------------
  logic w_wr_hs, w_rd_hs;
  assign w_wr_hs      = axil.AWVALID && axil.WVALID && !bvalid_q && ARESETN;
  assign w_rd_hs      = axil.ARVALID && !rvalid_q;
  assign axil.AWREADY = w_wr_hs;
  assign axil.WREADY  = w_wr_hs;
  assign axil.ARREADY = !rvalid_q;
  assign axil.BVALID  = bvalid_q;
  assign axil.BRESP   = bresp_q;
  assign axil.RVALID  = rvalid_q;
  assign axil.RRESP   = rresp_q;
  assign axil.RDATA   = rdata_q;
  assign NEW_IMAGE    = new_image_q;
  assign IRQ          = irq_q;

  logic w_ctrl_wr, w_status_wr, w_start_req, w_start, w_ovr_set, w_done_evt;
  logic w_img_wr, w_wr_err;
  assign w_ctrl_wr   = w_wr_hs && w_wr_reg && (w_wr_word[1:0] == 2'd0) && axil.WSTRB[0];
  assign w_status_wr = w_wr_hs && w_wr_reg && (w_wr_word[1:0] == 2'd1) && axil.WSTRB[0];
  assign w_start_req = w_ctrl_wr && axil.WDATA[0];
  // START is judged against the pre-edge BUSY, so a coincident SNN_DONE still overruns
  assign w_start     = w_start_req && !busy_q;
  assign w_ovr_set   = w_start_req && busy_q;
  assign w_done_evt  = SNN_DONE && busy_q;
  assign w_img_wr    = w_wr_hs && w_wr_img && !busy_q;
  assign w_wr_err    = (!w_wr_reg && !w_wr_img) || (w_wr_img && busy_q);

  // ---------------- image storage ----------------
  logic [AXI_DATA_WIDTH-1:0]             w_wmask;
  logic [NWORDS-1:0][AXI_DATA_WIDTH-1:0] w_img_words;

  for (genvar b = 0; b < NLANES; b++) begin : g_lane
    assign w_wmask[b*8 +: 8] = {8{axil.WSTRB[b]}};
  end

  for (genvar p = 0; p < IMAGE_SIZE; p++) begin : g_pix
    localparam int WI = p / PPW;
    localparam int LJ = p % PPW;
    logic [PIXEL_BITS-1:0] pix_q;
    logic [PIXEL_BITS-1:0] w_m;
    assign w_m = w_wmask[LJ*PIXEL_BITS +: PIXEL_BITS];
    always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
        pix_q <= '0;
      end else if (w_img_wr && (w_wr_k == KW'(WI))) begin
        pix_q <= (pix_q & ~w_m) | (axil.WDATA[LJ*PIXEL_BITS +: PIXEL_BITS] & w_m);
      end
    end
    assign IMAGE[p] = pix_q;
    assign w_img_words[WI][LJ*PIXEL_BITS +: PIXEL_BITS] = pix_q;
  end

  // Lanes past the last pixel read as zero and are never written
  for (genvar q = IMAGE_SIZE; q < NWORDS*PPW; q++) begin : g_pad
    assign w_img_words[q/PPW][(q%PPW)*PIXEL_BITS +: PIXEL_BITS] = '0;
  end

  // ---------------- read mux ----------------
  logic [AXI_DATA_WIDTH-1:0] w_rd_data;
  logic                      w_rd_err;
  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    if (w_rd_reg) begin
      case (w_rd_word[1:0])
        2'd0:    w_rd_data = AXI_DATA_WIDTH'({irq_en_q, 1'b0});
        2'd1:    w_rd_data = AXI_DATA_WIDTH'({ovr_q, done_q, busy_q});
        2'd2:    w_rd_data = AXI_DATA_WIDTH'(result_q);
        default: w_rd_data = AXI_DATA_WIDTH'(count_q);
      endcase
    end else if (w_rd_img) begin
      w_rd_data = w_img_words[w_rd_k];
    end else begin
      w_rd_err = 1'b1;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    busy_d      = busy_q;
    done_d      = done_q;
    ovr_d       = ovr_q;
    result_d    = result_q;
    count_d     = count_q;
    new_image_d = 1'b0;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;

    if (w_start) begin
      busy_d      = 1'b1;
      new_image_d = 1'b1;
    end
    if (w_done_evt) begin
      busy_d   = 1'b0;
      result_d = INFERED_DIGIT;
      count_d  = count_q + 32'd1;
    end
    if (w_status_wr && axil.WDATA[1]) done_d = 1'b0;
    if (w_done_evt)                   done_d = 1'b1;
    if (w_status_wr && axil.WDATA[2]) ovr_d  = 1'b0;
    if (w_ovr_set)                    ovr_d  = 1'b1;

    if (w_wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = w_wr_err ? RESP_SLVERR : RESP_OKAY;
    end else if (axil.BREADY) begin
      bvalid_d = 1'b0;
    end

    if (w_rd_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = w_rd_err ? RESP_SLVERR : RESP_OKAY;
      rdata_d  = w_rd_data;
    end else if (axil.RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      result_q    <= '0;
      count_q     <= '0;
      new_image_q <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      result_q    <= result_d;
      count_q     <= count_d;
      new_image_q <= new_image_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

  // ---------------- completion interrupt ----------------
`ifdef SNN_AXIL_IRQ_EN
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (w_ctrl_wr) irq_en_q <= axil.WDATA[1];
      irq_q <= done_q && irq_en_q;
    end
  end
`else
  assign irq_en_q = 1'b0;
  assign irq_q    = 1'b0;
`endif

  logic w_unused;
  assign w_unused = ^{axil.AWPROT, axil.ARPROT, axil.AWADDR[1:0], axil.ARADDR[1:0],
                      axil.WDATA, w_wr_off, w_rd_off};

endmodule
`default_nettype wire

// File: tb/tb_snn_axil_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_snn_axil_ctrl                                             |
// | Description : Scoreboard bench for snn_axil_ctrl with directed vectors.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_snn_axil_ctrl;

`ifdef SNN_AXIL_IRQ_EN
  localparam logic [31:0] IRQ_ON = 32'd1;
`else
  localparam logic [31:0] IRQ_ON = 32'd0;
`endif
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVE = 2'b10;

  logic       ACLK;
  logic       ARESETN;
  logic       SNN_DONE;
  logic [7:0] INFERED_DIGIT;
  logic       NEW_IMAGE;
  logic       IRQ;
  logic [7:0] IMAGE [256];

  snn_axil_ctrl_if #(.AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32)) axil ();

  snn_axil_ctrl #(
    .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(12), .IMAGE_SIZE(256), .PIXEL_BITS(8), .M(8)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .axil(axil), .IMAGE(IMAGE),
    .NEW_IMAGE(NEW_IMAGE), .SNN_DONE(SNN_DONE), .INFERED_DIGIT(INFERED_DIGIT), .IRQ(IRQ)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    string       name;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ni_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected, expected response", nm);
  endtask

  // Response monitor: pops the scoreboard on every accepted B/R beat
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (axil.BVALID && axil.BREADY) begin
        if (wq.size() == 0) fail_now("unexpected_bvalid");
        else begin
          exp_t e;
          e = wq.pop_front();
          check({e.name, "_bresp"}, {30'd0, axil.BRESP}, {30'd0, e.resp});
        end
      end
      if (axil.RVALID && axil.RREADY) begin
        if (rq.size() == 0) fail_now("unexpected_rvalid");
        else begin
          exp_t e;
          e = rq.pop_front();
          check({e.name, "_rresp"}, {30'd0, axil.RRESP}, {30'd0, e.resp});
          check({e.name, "_rdata"}, axil.RDATA, e.data);
        end
      end
    end
  end

  always @(negedge ACLK) if (NEW_IMAGE) ni_cnt++;

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] resp, input string nm);
    exp_t e;
    int   t;
    e.data = '0; e.resp = resp; e.name = nm;
    wq.push_back(e);
    @(negedge ACLK);
    axil.AWADDR = a; axil.WDATA = d; axil.WSTRB = s;
    axil.AWVALID = 1'b1; axil.WVALID = 1'b1;
    #1;
    t = 0;
    while (!axil.AWREADY && t < 50) begin
      @(negedge ACLK); #1; t++;
    end
    if (!axil.AWREADY) fail_now({nm, "_awready"});
    @(posedge ACLK); #1;
    axil.AWVALID = 1'b0; axil.WVALID = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic [1:0] resp,
                    input string nm);
    exp_t e;
    int   t;
    e.data = d; e.resp = resp; e.name = nm;
    rq.push_back(e);
    @(negedge ACLK);
    axil.ARADDR = a; axil.ARVALID = 1'b1;
    #1;
    t = 0;
    while (!axil.ARREADY && t < 50) begin
      @(negedge ACLK); #1; t++;
    end
    if (!axil.ARREADY) fail_now({nm, "_arready"});
    @(posedge ACLK); #1;
    axil.ARVALID = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((wq.size() != 0 || rq.size() != 0) && t < 100) begin
      @(negedge ACLK); t++;
    end
    if (wq.size() != 0 || rq.size() != 0) fail_now("drain");
    @(posedge ACLK); #1;
  endtask

  task automatic done_pulse(input logic [7:0] dig);
    @(negedge ACLK);
    SNN_DONE = 1'b1; INFERED_DIGIT = dig;
    @(posedge ACLK); #1;
    SNN_DONE = 1'b0; INFERED_DIGIT = 8'hEE;
  endtask

  // Write handshake and SNN_DONE land on the same clock edge
  task automatic wr_with_done(input logic [11:0] a, input logic [31:0] d,
                              input logic [7:0] dig, input string nm);
    exp_t e;
    drain();
    e.data = '0; e.resp = OKAY; e.name = nm;
    wq.push_back(e);
    @(negedge ACLK);
    axil.AWADDR = a; axil.WDATA = d; axil.WSTRB = 4'hF;
    axil.AWVALID = 1'b1; axil.WVALID = 1'b1;
    SNN_DONE = 1'b1; INFERED_DIGIT = dig;
    #1;
    check({nm, "_awready"}, {31'd0, axil.AWREADY}, 32'd1);
    @(posedge ACLK); #1;
    axil.AWVALID = 1'b0; axil.WVALID = 1'b0;
    SNN_DONE = 1'b0; INFERED_DIGIT = 8'hEE;
  endtask

  initial begin
    ARESETN = 1'b0; SNN_DONE = 1'b0; INFERED_DIGIT = '0;
    axil.AWADDR = '0; axil.AWPROT = '0; axil.AWVALID = 1'b0;
    axil.WDATA = '0; axil.WSTRB = '0; axil.WVALID = 1'b0; axil.BREADY = 1'b1;
    axil.ARADDR = '0; axil.ARPROT = '0; axil.ARVALID = 1'b0; axil.RREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK); ARESETN = 1'b1;
    @(negedge ACLK); #1;
    check("rst_arready", {31'd0, axil.ARREADY}, 32'd1);
    check("rst_awready", {31'd0, axil.AWREADY}, 32'd0);
    check("rst_bvalid",  {31'd0, axil.BVALID},  32'd0);
    check("rst_rvalid",  {31'd0, axil.RVALID},  32'd0);
    check("rst_newimg",  {31'd0, NEW_IMAGE},    32'd0);
    check("rst_irq",     {31'd0, IRQ},          32'd0);
    check("rst_pix255",  {24'd0, IMAGE[255]},   32'd0);

    rd(12'h004, 32'h0, OKAY, "rst_status");
    rd(12'h000, 32'h0, OKAY, "rst_ctrl");

    wr(12'h400, 32'hDDCCBBAA, 4'b0101, OKAY, "img0_strb");
    check("pix0", {24'd0, IMAGE[0]}, 32'hAA);
    check("pix1", {24'd0, IMAGE[1]}, 32'h00);
    check("pix2", {24'd0, IMAGE[2]}, 32'hCC);
    check("pix3", {24'd0, IMAGE[3]}, 32'h00);
    rd(12'h400, 32'h00CC00AA, OKAY, "img0_rb");
    wr(12'h404, 32'h44332211, 4'hF, OKAY, "img1");
    rd(12'h404, 32'h44332211, OKAY, "img1_rb");
    wr(12'h4FC, 32'h80706050, 4'hF, OKAY, "img_last");
    check("pix255", {24'd0, IMAGE[255]}, 32'h80);
    rd(12'h4FC, 32'h80706050, OKAY, "img_last_rb");
    wr(12'h500, 32'h12345678, 4'hF, SLVE, "img_oob_wr");
    rd(12'h500, 32'h0, SLVE, "img_oob_rd");
    drain();
    check("ni_before_start", ni_cnt, 32'd0);

    wr(12'h000, 32'h3, 4'hF, OKAY, "start1");
    rd(12'h004, 32'h1, OKAY, "status_busy");
    rd(12'h000, IRQ_ON << 1, OKAY, "ctrl_irqen");
    wr(12'h404, 32'hFFFFFFFF, 4'hF, SLVE, "img_wr_busy");
    rd(12'h404, 32'h44332211, OKAY, "img_busy_rb");
    check("pix4_busy", {24'd0, IMAGE[4]}, 32'h11);
    wr(12'h000, 32'h1, 4'hF, OKAY, "start2");
    rd(12'h004, 32'h5, OKAY, "status_ovr");
    drain();
    check("ni_one_pulse", ni_cnt, 32'd1);

    done_pulse(8'd7);
    rd(12'h008, 32'd7, OKAY, "result7");
    rd(12'h00C, 32'd1, OKAY, "count1");
    rd(12'h004, 32'h6, OKAY, "status_done");
    check("irq_set", {31'd0, IRQ}, IRQ_ON);
    wr(12'h004, 32'h2, 4'hF, OKAY, "w1c_done");
    rd(12'h004, 32'h4, OKAY, "status_w1c");
    drain();
    check("irq_clr", {31'd0, IRQ}, 32'd0);

    done_pulse(8'd9);
    rd(12'h008, 32'd7, OKAY, "idle_done_result");
    rd(12'h00C, 32'd1, OKAY, "idle_done_count");
    wr(12'h004, 32'h4, 4'hF, OKAY, "w1c_ovr");
    rd(12'h004, 32'h0, OKAY, "status_clear");
    wr(12'h008, 32'hFF, 4'hF, OKAY, "ro_result_wr");
    rd(12'h008, 32'd7, OKAY, "ro_result_rb");
    wr(12'h00C, 32'h55, 4'hF, OKAY, "ro_count_wr");
    rd(12'h00C, 32'd1, OKAY, "ro_count_rb");
    rd(12'h010, 32'h0, SLVE, "hole_rd");
    rd(12'h800, 32'h0, SLVE, "far_rd");
    wr(12'h010, 32'h1, 4'hF, SLVE, "hole_wr");
    drain();

    axil.BREADY = 1'b0;
    wr(12'h408, 32'h0D0C0B0A, 4'hF, OKAY, "bhold");
    @(negedge ACLK);
    axil.AWADDR = 12'h40C; axil.WDATA = 32'hDEADBEEF; axil.WSTRB = 4'hF;
    axil.AWVALID = 1'b1; axil.WVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bhold_bvalid",  {31'd0, axil.BVALID},  32'd1);
      check("bhold_awready", {31'd0, axil.AWREADY}, 32'd0);
      @(negedge ACLK);
    end
    axil.AWVALID = 1'b0; axil.WVALID = 1'b0;
    axil.BREADY = 1'b1;
    drain();
    rd(12'h408, 32'h0D0C0B0A, OKAY, "bhold_rb");
    rd(12'h40C, 32'h0, OKAY, "bhold_blocked_rb");

    wr(12'h000, 32'h1, 4'hF, OKAY, "start3");
    wr_with_done(12'h000, 32'h1, 8'd3, "start_vs_done");
    rd(12'h004, 32'h6, OKAY, "svd_status");
    rd(12'h008, 32'd3, OKAY, "svd_result");
    rd(12'h00C, 32'd2, OKAY, "svd_count");
    drain();
    check("svd_ni", ni_cnt, 32'd2);

    wr(12'h004, 32'h6, 4'hF, OKAY, "w1c_both");
    rd(12'h004, 32'h0, OKAY, "w1c_both_rb");
    wr(12'h000, 32'h1, 4'hF, OKAY, "start4");
    wr_with_done(12'h004, 32'h2, 8'd4, "w1c_vs_done");
    rd(12'h004, 32'h2, OKAY, "wvd_status");
    rd(12'h00C, 32'd3, OKAY, "wvd_count");

    wr(12'h000, 32'h1, 4'hF, OKAY, "start5");
    drain();
    axil.RREADY = 1'b0;
    rd(12'h004, 32'h1, OKAY, "pending_rd");
    @(negedge ACLK);
    check("pre_rst_rvalid", {31'd0, axil.RVALID}, 32'd1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    rq.delete();
    #1;
    check("mid_rst_rvalid", {31'd0, axil.RVALID}, 32'd0);
    check("mid_rst_newimg", {31'd0, NEW_IMAGE},   32'd0);
    check("mid_rst_pix0",   {24'd0, IMAGE[0]},    32'd0);
    check("mid_rst_pix255", {24'd0, IMAGE[255]},  32'd0);
    axil.RREADY = 1'b1;
    rd(12'h004, 32'h0, OKAY, "post_rst_status");
    rd(12'h00C, 32'h0, OKAY, "post_rst_count");
    rd(12'h400, 32'h0, OKAY, "post_rst_img");
    rd(12'h008, 32'h0, OKAY, "post_rst_result");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snn_axil_ctrl.md
# snn_axil_ctrl

AXI4-Lite slave that sits between the host processor and the SNN core. It stores a packed image buffer of `IMAGE_SIZE` pixels and exposes a control/status register set. It runs a start/busy/done handshake with the core and captures the inferred digit on completion. It replaces the single-flag image loader with byte-packed pixel words, read-back of every register, error responses and an optional completion interrupt.

## Interface
- `AXI_DATA_WIDTH`, 32, data bus width; must be a multiple of `PIXEL_BITS`.
- `AXI_ADDR_WIDTH`, 12, address bus width.
- `IMAGE_SIZE`, 256, number of pixels.
- `PIXEL_BITS`, 8, bits per pixel. `PPW = AXI_DATA_WIDTH/PIXEL_BITS` pixels per word.
- `M`, 8, width of the inferred digit.
- Clock and reset: one clock, `ACLK`; reset `ARESETN` is synchronous and active-low.
- `ACLK`  in  1  clock.
- `ARESETN`  in  1  synchronous active-low reset.
- `AWADDR/AWPROT/AWVALID/AWREADY`, `WDATA/WSTRB/WVALID/WREADY`, `BRESP/BVALID/BREADY`, `ARADDR/ARPROT/ARVALID/ARREADY`, `RDATA/RRESP/RVALID/RREADY`: standard AXI4-Lite ports. Widths follow the parameters; `*PROT` is ignored.
- `IMAGE`  out  `[PIXEL_BITS-1:0] x IMAGE_SIZE`  pixel array to the core.
- `NEW_IMAGE`  out  1  one-cycle start pulse to the core.
- `SNN_DONE`  in  1  one-cycle completion pulse from the core.
- `INFERED_DIGIT`  in  M  result; valid in the cycle `SNN_DONE` is high.
- `IRQ`  out  1  level interrupt (see Configuration).

## Operation
- Register map (word-aligned; `addr[1:0]` ignored):
  - `0x000 CTRL`: bit0 START, write-1 pulse, reads 0. bit1 IRQ_EN, R/W.
  - `0x004 STATUS`: bit0 BUSY (RO). bit1 DONE (sticky, write-1-to-clear). bit2 OVERRUN (sticky, W1C).
  - `0x008 RESULT`: `INFERED_DIGIT` captured at `SNN_DONE`, zero-extended; RO.
  - `0x00C COUNT`: 32-bit completed-inference counter; RO; wraps at 2^32 to 0.
  - `0x400 + 4k`, for k in `0..ceil(IMAGE_SIZE/PPW)-1`: image word. Pixel `k*PPW+j` occupies bits `[j*PIXEL_BITS +: PIXEL_BITS]`.
- Image writes honour `WSTRB` per byte lane. Lanes covering pixel indices at or beyond `IMAGE_SIZE` are discarded.
- START while BUSY=0: `NEW_IMAGE` pulses for one cycle in the cycle after the write handshake, and BUSY is set in that same cycle.
- START while BUSY=1 has no effect on the core. It sets OVERRUN.
- `SNN_DONE`: clears BUSY, loads RESULT, increments COUNT and sets DONE.
- `SNN_DONE` while BUSY=0 is ignored entirely.
- Image writes while BUSY=1 are discarded and answered with SLVERR, so the image stays stable during inference. Image reads are always permitted.
- Any address outside the map returns SLVERR (`2'b10`). Writes to it are discarded; reads return 0.
- Writes to RO registers are discarded and answered OKAY.
- W1C on DONE in the same cycle as `SNN_DONE`: set wins.
- START write in the same cycle as `SNN_DONE`: START is evaluated against the pre-edge BUSY=1, so the result is OVERRUN and no start.

## Timing
- Reset values:
  - `AWREADY`, `WREADY`, `BVALID`, `RVALID`, `NEW_IMAGE`, `IRQ` = 0.
  - `ARREADY` = 1; `BRESP`, `RRESP`, `RDATA` = 0.
  - All registers and all `IMAGE` pixels = 0.
- Write channel:
  - `AWREADY = WREADY = AWVALID && WVALID && !BVALID`; AW and W complete together.
  - The register update takes effect at the handshake edge.
  - `BVALID` rises in the next cycle and holds with a stable `BRESP` until `BREADY`.
  - One write is outstanding at most.
- Read channel:
  - `ARREADY = !RVALID`.
  - `RDATA`/`RRESP` are registered at the handshake edge, and `RVALID` is high from the next cycle until `RREADY`.
  - While `RVALID` is high, `RDATA` is stable.
- Read-to-data latency is 1 cycle. Write-to-`IMAGE` visibility is 1 cycle after the handshake edge.
- Reset asserted mid-transaction drops `BVALID`/`RVALID` at the next edge. A pending `NEW_IMAGE` is cancelled and BUSY is cleared.

## Configuration
- `SNN_AXIL_IRQ_EN` defined: `IRQ = DONE && IRQ_EN`, registered, so it rises 1 cycle after DONE is set. CTRL bit1 is R/W.
- Not defined: `IRQ` is tied to 0, CTRL bit1 is read-only 0, and writes to it are ignored.

## Test plan
- Reset, then read `0x004` → `RDATA=0`, `RRESP=0`. Read `0x000` → 0. `ARREADY=1` before the first read.
- Write `0x400` with `0xDDCCBBAA` and `WSTRB=4'b0101` → `IMAGE[0]=0xAA`, `IMAGE[2]=0xCC`, `IMAGE[1]=IMAGE[3]=0`. Read-back returns `0x00CC00AA`.
- Write START → exactly one `NEW_IMAGE` cycle, STATUS=1. Write `0x404` → `BRESP=2'b10` and the image is unchanged. Second START → STATUS=`0x5`.
- Pulse `SNN_DONE` with `INFERED_DIGIT=7` → RESULT=7, COUNT=1, STATUS=`0x6`. With the macro and IRQ_EN=1, `IRQ=1`. Write `0x2` to STATUS → DONE and `IRQ` clear.
- Read `0x010` and `0x800` → `RRESP=2'b10`, `RDATA=0`. Hold `BREADY=0` for 5 cycles → `BVALID` holds and `AWREADY` stays 0 throughout.
- Assert `ARESETN=0` for one cycle while BUSY=1 and `RVALID=1` → next cycle BUSY=0, `RVALID=0`, `IMAGE` cleared.
